uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial receive stage that consumes the TxD line produced by the UART transmitter and rebuilds bytes.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit (XOR of the data bits, even parity), 1 stop bit (1).
- Each bit lasts 16 sample ticks.
- The block instantiates BaudController internally with the same baud_select encoding as the transmitter, so the two ends run at identical rates.
- It sits directly downstream of the transmitter; on the board it faces the external RX pin.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; tick counter is 4 bits wide.
SYNC_STAGES, 2, flip-flop stages on the RxD input synchroniser.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
RxD  input  1  serial line; idles high.
baud_select  input  3  baud rate select; passed to the internal BaudController.
Rx_EN  input  1  receiver enable.
Rx_DATA  output  8  last correctly received byte.
Rx_VALID  output  1  one-clock pulse when Rx_DATA is updated.
Rx_PERROR  output  1  parity error flag for the last frame.
Rx_FERROR  output  1  framing error flag for the last frame (stop bit sampled 0).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; tick counter = 0; bit counter = 0; shift register = 0.
  - Rx_DATA = 0x00; Rx_VALID = 0; Rx_PERROR = 0; Rx_FERROR = 0.
- Input path:
  - RxD passes through SYNC_STAGES flops; all decisions use the synchronised value rs.
  - A one-flop delayed copy rs_d detects falling edges.
- Sample tick: tick = BaudController enable output. The tick counter advances only on tick.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- IDLE:
  - Go to START_BIT when Rx_EN=1 and rs_d=1, rs=0 (falling edge); clear the tick counter.
  - Edges while Rx_EN=0 are ignored.
- START_BIT: count ticks. On the tick where the counter = 7 (mid-bit):
  - rs=0: valid start. Clear the tick counter and bit counter, clear Rx_PERROR and Rx_FERROR, go to DATA_BITS.
  - rs=1: glitch. Return to IDLE; flags unchanged; no output.
- DATA_BITS:
  - On the tick where the counter = 15 (mid-bit): shift rs into the MSB of the shift register (shift right, so LSB-first reception), clear the counter, increment the bit counter.
  - After the 8th sample, go to PARITY_BIT.
- PARITY_BIT: on the tick where the counter = 15, latch perr = rs XOR (XOR of shift register). Clear the counter and go to STOP_BIT.
- STOP_BIT: on the tick where the counter = 15, sample rs and go to IDLE.
  - rs=1 and perr=0: next clock, Rx_DATA = shift register and Rx_VALID = 1 for exactly one clock.
  - rs=0: Rx_FERROR = 1.
  - perr=1: Rx_PERROR = 1.
  - Either error: Rx_DATA unchanged, no Rx_VALID.
- Output latency: Rx_VALID and the error flags assert one clk after the tick that samples the stop bit.
- Flag lifetime: flags hold until the next valid start bit or reset.
- Return to IDLE happens at mid-stop-bit. The line is high there, so the next frame's falling edge is caught. Back-to-back frames with zero idle time must be received.
- A stop bit of 0 (break or framing fault) with the line held low must not retrigger. A new start requires a 1-to-0 edge.
- Rx_EN dropped mid-frame: next clock go to IDLE, clear the counters, no Rx_VALID; Rx_DATA and flags unchanged.
- Reset mid-frame: all state returns to reset values immediately; no partial byte is ever presented.
- Counters are fixed width: the tick counter is 4 bits and wraps at 15→0; the bit counter is 3 bits and wraps after 7.

Test Plan:
- Loopback: connect transmitter TxD to RxD, same baud_select and both enables=1, write 0xA5 → one Rx_VALID pulse, Rx_DATA=0xA5, Rx_PERROR=Rx_FERROR=0; repeat for 0x00, 0xFF, 0x01, 0x80.
- Back-to-back: transmitter sends 0x3C then 0xC3 with no idle gap → two Rx_VALID pulses, in order, with the correct bytes.
- Parity fault: drive RxD manually with 0x55 and parity bit 1 (correct is 0) → Rx_PERROR=1, no Rx_VALID, Rx_DATA keeps its previous value; a following good frame 0x12 clears the flag and yields Rx_VALID with 0x12.
- Framing fault: frame 0x0F with stop bit 0, line then held low for 40 bit times → Rx_FERROR=1 exactly once, no retrigger until the line returns high and falls again.
- Glitch: RxD low for 4 ticks then high → state returns to IDLE, no Rx_VALID, flags unchanged.
- Abort: deassert Rx_EN during data bit 3 of 0x99, or assert reset mid-frame → no Rx_VALID; after reset Rx_DATA=0x00 and all flags=0; the next full frame 0x66 is received correctly.

Source files
------------

// File: rtl/uart_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_receiver_if
// Brief   : Serial line, control and received-byte signals of uart_receiver.
// Revision: 1.0
// ============================================================================
interface uart_receiver_if;
    logic       RxD;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    modport master (
        output RxD, baud_select, Rx_EN,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

    modport slave (
        input  RxD, baud_select, Rx_EN,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : baud_controller, uart_receiver
// Brief   : Oversampling UART receiver (8 data bits, even parity, 1 stop).
// Revision: 1.0
// ============================================================================
module baud_controller #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);
    function automatic logic [15:0] div_for(input int rate);
        int d;
        d = CLK_HZ / (OVERSAMPLE * rate);
        if (d < 1) d = 1;
        return 16'(d);
    endfunction

    localparam logic [15:0] DIV_0 = div_for(300);
    localparam logic [15:0] DIV_1 = div_for(1200);
    localparam logic [15:0] DIV_2 = div_for(4800);
    localparam logic [15:0] DIV_3 = div_for(9600);
    localparam logic [15:0] DIV_4 = div_for(19200);
    localparam logic [15:0] DIV_5 = div_for(38400);
    localparam logic [15:0] DIV_6 = div_for(57600);
    localparam logic [15:0] DIV_7 = div_for(115200);

    logic [15:0] div_w;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        case (baud_select)
            3'd0:    div_w = DIV_0;
            3'd1:    div_w = DIV_1;
            3'd2:    div_w = DIV_2;
            3'd3:    div_w = DIV_3;
            3'd4:    div_w = DIV_4;
            3'd5:    div_w = DIV_5;
            3'd6:    div_w = DIV_6;
            default: div_w = DIV_7;
        endcase
    end

    // >= rather than == so a switch to a faster rate cannot strand the counter
    always_comb begin
        cnt_d  = cnt_q + 16'd1;
        tick_d = 1'b0;
        if (cnt_q >= div_w - 16'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign sample_enable = tick_q;
endmodule

module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CLK_HZ      = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  rx_if
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } state_t;

    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   rs_d_q;

    state_t      state_q,    state_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        perr_q,     perr_d;
    logic [7:0]  data_q,     data_d;
    logic        valid_q,    valid_d;
    logic        perror_q,   perror_d;
    logic        ferror_q,   ferror_d;

    baud_controller #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (rx_if.baud_select),
        .sample_enable (tick)
    );

    assign rs = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perror_d   = perror_q;
        ferror_d   = ferror_q;

        if (!rx_if.Rx_EN) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Edge-triggered so a line stuck low after a break never restarts
                    if (rs_d_q && !rs) begin
                        state_d    = START_BIT;
                        tick_cnt_d = '0;
                    end
                end
                START_BIT: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == MID_CNT) begin
                            if (!rs) begin
                                state_d    = DATA_BITS;
                                tick_cnt_d = '0;
                                bit_cnt_d  = '0;
                                perror_d   = 1'b0;
                                ferror_d   = 1'b0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                DATA_BITS: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_CNT) begin
                            shift_d    = {rs, shift_q[7:1]};
                            tick_cnt_d = '0;
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_d = PARITY_BIT;
                        end
                    end
                end
                PARITY_BIT: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_CNT) begin
                            perr_d     = rs ^ (^shift_q);
                            tick_cnt_d = '0;
                            state_d    = STOP_BIT;
                        end
                    end
                end
                STOP_BIT: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == LAST_CNT) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = IDLE;
                            if (rs && !perr_q) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
                            if (!rs)   ferror_d = 1'b1;
                            if (perr_q) perror_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            rs_d_q     <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perror_q   <= 1'b0;
            ferror_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_if.RxD};
            rs_d_q     <= rs;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perror_q   <= perror_d;
            ferror_q   <= ferror_d;
        end
    end

    assign rx_if.Rx_DATA   = data_q;
    assign rx_if.Rx_VALID  = valid_q;
    assign rx_if.Rx_PERROR = perror_q;
    assign rx_if.Rx_FERROR = ferror_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_receiver
// Brief   : Directed frames on RxD with a scoreboard of expected bytes.
// Revision: 1.0
// ============================================================================
module tb_uart_receiver;
    // 5.5296 MHz / (16 * 115200) = 3 clocks per sample tick
    localparam int CLK_HZ   = 5_529_600;
    localparam int BIT_CLKS = 48;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_receiver_if bus ();

    uart_receiver #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2),
        .CLK_HZ      (CLK_HZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (bus)
    );

    int         n_cmp     = 0;
    int         n_err     = 0;
    int         valid_cnt = 0;
    int         fe_rise   = 0;
    logic [7:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int bits);
        repeat (bits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic monitor();
        logic fe_prev;
        logic [7:0] exp;
        fe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.Rx_FERROR && !fe_prev) fe_rise++;
            fe_prev = bus.Rx_FERROR;
            if (!reset && bus.Rx_VALID) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_valid", {31'd0, bus.Rx_VALID}, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("rx_data", {24'd0, bus.Rx_DATA}, {24'd0, exp});
                    check("valid_perror", {31'd0, bus.Rx_PERROR}, 32'd0);
                    check("valid_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);
                end
            end
        end
    endtask

    // abort_kind 0 drops Rx_EN mid-bit, 1 pulses reset mid-bit and ends the frame
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                              input int abort_bit, input int abort_kind);
        logic [10:0] fr;
        fr = {stop_bit, (^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.RxD = fr[i];
            if (i == abort_bit) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                if (abort_kind == 0) begin
                    bus.Rx_EN = 1'b0;
                end else begin
                    reset   = 1'b1;
                    bus.RxD = 1'b1;
                    repeat (3) @(negedge clk);
                    reset = 1'b0;
                    return;
                end
                repeat (BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
            end else begin
                repeat (BIT_CLKS) @(negedge clk);
            end
        end
    endtask

    logic [7:0] loop_bytes [5];
    int v0;
    int f0;

    initial begin
        loop_bytes[0] = 8'hA5; loop_bytes[1] = 8'h00; loop_bytes[2] = 8'hFF;
        loop_bytes[3] = 8'h01; loop_bytes[4] = 8'h80;
        bus.RxD         = 1'b1;
        bus.baud_select = 3'd7;
        bus.Rx_EN       = 1'b1;
        reset           = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_data",   {24'd0, bus.Rx_DATA},   32'd0);
        check("reset_valid",  {31'd0, bus.Rx_VALID},  32'd0);
        check("reset_perror", {31'd0, bus.Rx_PERROR}, 32'd0);
        check("reset_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);
        reset = 1'b0;
        idle(2);

        foreach (loop_bytes[i]) begin
            sb.push_back(loop_bytes[i]);
            send_frame(loop_bytes[i], 1'b0, 1'b1, -1, 0);
            idle(1);
            check("loop_perror", {31'd0, bus.Rx_PERROR}, 32'd0);
            check("loop_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);
        end

        sb.push_back(8'h3C);
        sb.push_back(8'hC3);
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0);
        send_frame(8'hC3, 1'b0, 1'b1, -1, 0);
        idle(1);
        check("b2b_valid_count", valid_cnt, 32'd7);

        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 1'b1, -1, 0);
        idle(1);
        check("par_perror", {31'd0, bus.Rx_PERROR}, 32'd1);
        check("par_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);
        check("par_data_kept", {24'd0, bus.Rx_DATA}, 32'hC3);
        check("par_no_valid", valid_cnt - v0, 32'd0);
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1, -1, 0);
        idle(1);
        check("par_clear", {31'd0, bus.Rx_PERROR}, 32'd0);
        check("par_next_data", {24'd0, bus.Rx_DATA}, 32'h12);

        v0 = valid_cnt;
        f0 = fe_rise;
        send_frame(8'h0F, 1'b0, 1'b0, -1, 0);
        idle(40);
        check("frm_ferror", {31'd0, bus.Rx_FERROR}, 32'd1);
        check("frm_perror", {31'd0, bus.Rx_PERROR}, 32'd0);
        check("frm_data_kept", {24'd0, bus.Rx_DATA}, 32'h12);
        check("frm_ferror_once", fe_rise - f0, 32'd1);
        check("frm_no_valid", valid_cnt - v0, 32'd0);
        bus.RxD = 1'b1;
        idle(2);

        bus.RxD = 1'b0;
        repeat (12) @(negedge clk);
        bus.RxD = 1'b1;
        idle(2);
        check("glitch_no_valid", valid_cnt - v0, 32'd0);
        check("glitch_ferror_kept", {31'd0, bus.Rx_FERROR}, 32'd1);
        check("glitch_data_kept", {24'd0, bus.Rx_DATA}, 32'h12);

        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
        idle(1);
        check("recover_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);

        v0 = valid_cnt;
        send_frame(8'h99, 1'b0, 1'b1, 4, 0);
        idle(1);
        bus.Rx_EN = 1'b1;
        idle(1);
        check("en_abort_no_valid", valid_cnt - v0, 32'd0);
        check("en_abort_data_kept", {24'd0, bus.Rx_DATA}, 32'h5A);
        check("en_abort_perror", {31'd0, bus.Rx_PERROR}, 32'd0);

        send_frame(8'h33, 1'b1, 1'b1, -1, 0);
        idle(1);
        check("pre_reset_perror", {31'd0, bus.Rx_PERROR}, 32'd1);
        v0 = valid_cnt;
        send_frame(8'h99, 1'b0, 1'b1, 5, 1);
        idle(1);
        check("rst_abort_no_valid", valid_cnt - v0, 32'd0);
        check("rst_abort_data", {24'd0, bus.Rx_DATA}, 32'd0);
        check("rst_abort_perror", {31'd0, bus.Rx_PERROR}, 32'd0);
        check("rst_abort_ferror", {31'd0, bus.Rx_FERROR}, 32'd0);
        sb.push_back(8'h66);
        send_frame(8'h66, 1'b0, 1'b1, -1, 0);
        idle(1);
        check("after_reset_data", {24'd0, bus.Rx_DATA}, 32'h66);

        idle(2);
        check("scoreboard_empty", sb.size(), 32'd0);
        check("total_valid", valid_cnt, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
